// File: rtl/bus_cycle_controller.sv
// rtl/bus_cycle_controller.sv - 6809 bus-cycle tracker, address decoder and flash read stretcher
module bus_cycle_controller #(
  parameter logic [15:0] FLASH_BASE     = 16'hF000,
  parameter logic [15:0] FLASH_MASK     = 16'hF000,
  parameter logic [15:0] IO_BASE        = 16'hE000,
  parameter logic [15:0] IO_MASK        = 16'hFF00,
  parameter int          SETTLE_CYCLES  = 4,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_E,
  input  logic        i_Q,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic        i_RW,
  input  logic [7:0]  i_flash_data,
  input  logic        i_flash_ready,
  output logic        o_flash_ce,
  output logic        o_ram_ce,
  output logic        o_io_ce,
  output logic [7:0]  o_DATA,
  output logic        o_DATA_OE,
  output logic        o_MRDY,
  output logic        o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLASH_REQ,
    S_FLASH_WAIT,
    S_HOLD,
    S_IGNORE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  e_sync_q, e_sync_d, q_sync_q, q_sync_d;
  logic        e_prev_q, e_prev_d, q_prev_q, q_prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flash_ce_q, flash_ce_d, ram_ce_q, ram_ce_d, io_ce_q, io_ce_d;
  logic [7:0]  data_q, data_d;
  logic        data_oe_q, data_oe_d, mrdy_q, mrdy_d, timeout_err_q, timeout_err_d;
  logic        q_rise, e_fall, flash_hit, io_hit;

  always_comb begin
    e_sync_d      = {e_sync_q[0], i_E};
    q_sync_d      = {q_sync_q[0], i_Q};
    e_prev_d      = e_sync_q[1];
    q_prev_d      = q_sync_q[1];
    q_rise        = q_sync_q[1] & ~q_prev_q;
    e_fall        = ~e_sync_q[1] & e_prev_q;
    // Decode straight off the bus at q_rise so MRDY can drop on the very next edge
    flash_hit     = (i_ADDRESS_BUS & FLASH_MASK) == FLASH_BASE;
    io_hit        = (i_ADDRESS_BUS & IO_MASK) == IO_BASE;

    state_d       = state_q;
    cnt_d         = cnt_q;
    flash_ce_d    = flash_ce_q;
    ram_ce_d      = ram_ce_q;
    io_ce_d       = io_ce_q;
    data_d        = data_q;
    data_oe_d     = data_oe_q;
    mrdy_d        = mrdy_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (q_rise) begin
          cnt_d = 8'd0;
          if (flash_hit) begin
            if (i_RW) begin
              state_d    = S_FLASH_REQ;
              flash_ce_d = 1'b1;
              mrdy_d     = 1'b0;
            end else begin
              state_d = S_IGNORE;
            end
          end else if (io_hit) begin
            io_ce_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            ram_ce_d = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_FLASH_REQ: begin
        if (e_fall) begin
          state_d    = S_IDLE;
          flash_ce_d = 1'b0;
          mrdy_d     = 1'b1;
          cnt_d      = 8'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          // Settling hides the controller's ready-drop latency on a fresh address
          cnt_d   = 8'd0;
          state_d = S_FLASH_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FLASH_WAIT: begin
        if (e_fall) begin
          state_d    = S_IDLE;
          flash_ce_d = 1'b0;
          mrdy_d     = 1'b1;
          cnt_d      = 8'd0;
        end else if (i_flash_ready) begin
          data_d    = i_flash_data;
          data_oe_d = 1'b1;
          mrdy_d    = 1'b1;
          state_d   = S_HOLD;
        end else if (cnt_q == TMO_LAST) begin
          data_d        = 8'hFF;
          data_oe_d     = 1'b1;
          mrdy_d        = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (e_fall) begin
          flash_ce_d = 1'b0;
          ram_ce_d   = 1'b0;
          io_ce_d    = 1'b0;
          data_oe_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_IGNORE: begin
        if (e_fall) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      e_sync_q      <= 2'b00;
      q_sync_q      <= 2'b00;
      e_prev_q      <= 1'b0;
      q_prev_q      <= 1'b0;
      cnt_q         <= 8'd0;
      flash_ce_q    <= 1'b0;
      ram_ce_q      <= 1'b0;
      io_ce_q       <= 1'b0;
      data_q        <= 8'h00;
      data_oe_q     <= 1'b0;
      mrdy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      e_sync_q      <= e_sync_d;
      q_sync_q      <= q_sync_d;
      e_prev_q      <= e_prev_d;
      q_prev_q      <= q_prev_d;
      cnt_q         <= cnt_d;
      flash_ce_q    <= flash_ce_d;
      ram_ce_q      <= ram_ce_d;
      io_ce_q       <= io_ce_d;
      data_q        <= data_d;
      data_oe_q     <= data_oe_d;
      mrdy_q        <= mrdy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign o_flash_ce    = flash_ce_q;
  assign o_ram_ce      = ram_ce_q;
  assign o_io_ce       = io_ce_q;
  assign o_DATA        = data_q;
  assign o_DATA_OE     = data_oe_q;
  assign o_MRDY        = mrdy_q;
  assign o_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// tb/tb_bus_cycle_controller.sv - directed bench for bus_cycle_controller with a 6809 bus and flash model
module tb_bus_cycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_E, i_Q, i_RW;
  logic [15:0] i_ADDRESS_BUS;
  logic [7:0]  i_flash_data;
  logic        i_flash_ready;
  logic        o_flash_ce, o_ram_ce, o_io_ce, o_DATA_OE, o_MRDY, o_timeout_err;
  logic [7:0]  o_DATA;

  always #5 clk = ~clk;

  bus_cycle_controller dut (
    .clk           (clk),
    .reset         (reset),
    .i_E           (i_E),
    .i_Q           (i_Q),
    .i_ADDRESS_BUS (i_ADDRESS_BUS),
    .i_RW          (i_RW),
    .i_flash_data  (i_flash_data),
    .i_flash_ready (i_flash_ready),
    .o_flash_ce    (o_flash_ce),
    .o_ram_ce      (o_ram_ce),
    .o_io_ce       (o_io_ce),
    .o_DATA        (o_DATA),
    .o_DATA_OE     (o_DATA_OE),
    .o_MRDY        (o_MRDY),
    .o_timeout_err (o_timeout_err)
  );

  int errors = 0;
  int checks = 0;

  int   cyc_tick, first_low, low_cnt, ce_rises;
  logic ce_prev = 1'b0;
  logic [2:0] hold_sel;
  logic [7:0] hold_data;
  logic       hold_oe;

  // Flash controller model knobs
  int         f_lat  = 90;
  logic       f_hang = 1'b0;
  logic       f_skip = 1'b0;
  logic [7:0] f_data = 8'h00;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_tick++;
    if (!o_MRDY) begin
      low_cnt++;
      if (first_low < 0) first_low = cyc_tick;
    end
    if (o_flash_ce && !ce_prev) ce_rises++;
    ce_prev = o_flash_ce;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One 6809 cycle: Q rise, E rise, Q fall, E held high while MRDY is low, E fall, E-low quarter
  task automatic bus_cycle(input logic [15:0] a, input logic r);
    int guard;
    i_ADDRESS_BUS = a;
    i_RW          = r;
    cyc_tick      = 0;
    first_low     = -1;
    low_cnt       = 0;
    ce_rises      = 0;
    i_Q = 1'b1; steps(4);
    i_E = 1'b1; steps(4);
    i_Q = 1'b0; steps(4);
    guard = 0;
    while (!o_MRDY && guard < 400) begin
      step();
      guard++;
    end
    if (!o_MRDY) check_eq("mrdy_release_bound", int'(o_MRDY), 1);
    hold_sel  = {o_flash_ce, o_ram_ce, o_io_ce};
    hold_data = o_DATA;
    hold_oe   = o_DATA_OE;
    i_E = 1'b0; steps(4);
  endtask

  initial begin : flash_model
    int   fm_cnt;
    logic fm_busy, fm_prev;
    i_flash_ready = 1'b1;
    i_flash_data  = 8'h00;
    fm_cnt  = 0;
    fm_busy = 1'b0;
    fm_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (o_flash_ce && !fm_prev && !f_skip) begin
        fm_busy       = 1'b1;
        fm_cnt        = 0;
        i_flash_ready = 1'b0;
      end else if (fm_busy) begin
        fm_cnt++;
        if (!f_hang && fm_cnt == f_lat) begin
          i_flash_ready = 1'b1;
          i_flash_data  = f_data;
          fm_busy       = 1'b0;
        end
      end
      fm_prev = o_flash_ce;
    end
  end

  initial begin
    reset = 1'b0; i_E = 1'b0; i_Q = 1'b0; i_RW = 1'b1; i_ADDRESS_BUS = 16'h0000;
    steps(3);
    check_eq("rst_mrdy", int'(o_MRDY), 1);
    check_eq("rst_oe", int'(o_DATA_OE), 0);
    check_eq("rst_sel", int'({o_flash_ce, o_ram_ce, o_io_ce}), 0);
    check_eq("rst_data", int'(o_DATA), 0);
    check_eq("rst_err", int'(o_timeout_err), 0);
    reset = 1'b1;
    steps(2);

    bus_cycle(16'hE010, 1'b1);
    check_eq("io_stretch", low_cnt, 0);
    check_eq("io_sel", int'(hold_sel), 3'b001);
    check_eq("io_clear", int'({o_flash_ce, o_ram_ce, o_io_ce, o_DATA_OE}), 0);

    bus_cycle(16'h1234, 1'b1);
    check_eq("ram_stretch", low_cnt, 0);
    check_eq("ram_sel", int'(hold_sel), 3'b010);

    bus_cycle(16'hF000, 1'b0);
    check_eq("fwr_stretch", low_cnt, 0);
    check_eq("fwr_sel", int'(hold_sel), 0);

    // Ready returns 90 cycles after ce rises; MRDY releases one edge later
    f_lat = 90; f_data = 8'hA5;
    bus_cycle(16'hF123, 1'b1);
    check_eq("fr_mrdy_lat", first_low, 3);
    check_eq("fr_stretch", low_cnt, 91);
    check_eq("fr_data", int'(hold_data), 8'hA5);
    check_eq("fr_oe", int'(hold_oe), 1);
    check_eq("fr_sel", int'(hold_sel), 3'b100);
    check_eq("fr_ce_pulses", ce_rises, 1);
    check_eq("fr_clear", int'({o_flash_ce, o_ram_ce, o_io_ce, o_DATA_OE}), 0);

    f_skip = 1'b1;
    bus_cycle(16'hF123, 1'b1);
    check_eq("rep_stretch", low_cnt, 5);
    check_eq("rep_data", int'(hold_data), 8'hA5);
    check_eq("rep_err", int'(o_timeout_err), 0);
    f_skip = 1'b0;

    f_lat = 20; f_data = 8'h3C;
    bus_cycle(16'hF001, 1'b1);
    check_eq("b2b1_data", int'(hold_data), 8'h3C);
    check_eq("b2b1_stretch", low_cnt, 21);
    check_eq("b2b1_ce_pulses", ce_rises, 1);
    f_data = 8'hC3;
    bus_cycle(16'hF002, 1'b1);
    check_eq("b2b2_data", int'(hold_data), 8'hC3);
    check_eq("b2b2_ce_pulses", ce_rises, 1);

    f_hang = 1'b1;
    bus_cycle(16'hF200, 1'b1);
    check_eq("tmo_stretch", low_cnt, 259);
    check_eq("tmo_data", int'(hold_data), 8'hFF);
    check_eq("tmo_oe", int'(hold_oe), 1);
    check_eq("tmo_err", int'(o_timeout_err), 1);

    f_hang = 1'b0; f_lat = 10; f_data = 8'h5A;
    bus_cycle(16'hF010, 1'b1);
    check_eq("post_tmo_data", int'(hold_data), 8'h5A);
    check_eq("post_tmo_stretch", low_cnt, 11);
    check_eq("err_sticky", int'(o_timeout_err), 1);

    // Reset while parked in the flash wait
    f_hang = 1'b1;
    i_ADDRESS_BUS = 16'hF123; i_RW = 1'b1;
    cyc_tick = 0; first_low = -1; low_cnt = 0;
    i_Q = 1'b1; steps(4);
    i_E = 1'b1; steps(20);
    check_eq("pre_rst_stretch", int'(o_MRDY), 0);
    reset = 1'b0;
    step();
    check_eq("mid_rst_mrdy", int'(o_MRDY), 1);
    check_eq("mid_rst_oe", int'(o_DATA_OE), 0);
    check_eq("mid_rst_sel", int'({o_flash_ce, o_ram_ce, o_io_ce}), 0);
    check_eq("mid_rst_err", int'(o_timeout_err), 0);
    steps(2);
    i_E = 1'b0; i_Q = 1'b0;
    reset = 1'b1;
    steps(4);
    f_hang = 1'b0;

    bus_cycle(16'h0042, 1'b1);
    check_eq("post_rst_ram_sel", int'(hold_sel), 3'b010);
    check_eq("post_rst_stretch", low_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_cycle_controller.md
Name: bus_cycle_controller

Overview:
- Front-end between the 6809 bus and the on-board memory/peripheral selects.
- Tracks each 6809 bus cycle using synchronised E/Q, then decodes the address into flash, I/O or RAM selects.
- For flash-window reads, drives the SPI flash controller's chip-enable, stretches the CPU cycle via MRDY until flash data is ready, then latches the byte and drives it onto the CPU data bus.
- Includes a timeout watchdog so a stuck flash transaction cannot hang the CPU indefinitely.

Parameters:
- FLASH_BASE, 16'hF000, flash window base; match when (addr & FLASH_MASK) == FLASH_BASE.
- FLASH_MASK, 16'hF000, flash window mask (4 KB window).
- IO_BASE, 16'hE000, I/O window base.
- IO_MASK, 16'hFF00, I/O window mask (256 B).
- SETTLE_CYCLES, 4, clk cycles after raising o_flash_ce before i_flash_ready is sampled.
- TIMEOUT_CYCLES, 255, max clk cycles in FLASH_WAIT before abort; 8-bit counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- i_E  in  1  6809 E clock (asynchronous to clk).
- i_Q  in  1  6809 Q clock (asynchronous to clk).
- i_ADDRESS_BUS  in  16  CPU address.
- i_RW  in  1  1 = read, 0 = write.
- i_flash_data  in  8  byte from SPI flash controller.
- i_flash_ready  in  1  flash controller ready (low while SPI transfer busy).
- o_flash_ce  out  1  chip-enable to flash controller.
- o_ram_ce  out  1  RAM select.
- o_io_ce  out  1  I/O select.
- o_DATA  out  8  data to CPU bus.
- o_DATA_OE  out  1  enable for the CPU data-bus driver.
- o_MRDY  out  1  6809 MRDY; low stretches E.
- o_timeout_err  out  1  sticky; set on flash timeout.

Behaviour:
- **Reset (reset==0 at posedge clk):** all outputs forced on the same edge.
  - o_flash_ce=0, o_ram_ce=0, o_io_ce=0, o_DATA=8'h00, o_DATA_OE=0, o_MRDY=1, o_timeout_err=0.
  - State=IDLE, counters=0.
  - Reset mid-transaction aborts immediately; o_MRDY releases to 1.
- **Synchronisers:** i_E and i_Q each pass through 2 flops. Edge detects are taken on the synchronised values.
  - q_rise = Q rose.
  - e_fall = E fell (end of CPU cycle).
- **Address capture:** i_ADDRESS_BUS and i_RW are captured on q_rise (address is stable by Q rise).
  - Decode priority: flash > io > ram.
- **States:**
  - IDLE:
    - On q_rise with flash hit and read → FLASH_REQ; o_MRDY=0 on the next edge.
    - On flash hit and write → IGNORE (no selects, no stretch).
    - On io hit → assert o_io_ce; go to HOLD.
    - Otherwise → assert o_ram_ce; go to HOLD.
  - FLASH_REQ: o_flash_ce=1. Count SETTLE_CYCLES, then → FLASH_WAIT.
  - FLASH_WAIT: timeout counter increments each cycle.
    - If i_flash_ready==1: latch o_DATA<=i_flash_data, o_DATA_OE=1, o_MRDY=1 → HOLD.
    - If the counter reaches TIMEOUT_CYCLES: o_DATA<=8'hFF, o_DATA_OE=1, o_MRDY=1, o_timeout_err=1 → HOLD.
  - HOLD: selects and o_DATA_OE held until e_fall; then all selects=0, o_DATA_OE=0, o_flash_ce=0 → IDLE.
  - IGNORE: wait for e_fall → IDLE.
- **Repeat-address reads:** the flash controller keeps ready=1 and skips the transfer when the address repeats. SETTLE_CYCLES covers its ready-drop latency (≤2 cycles), so a stale ready is never sampled.
- **Stretch timing:** o_MRDY low no later than 3 clk after the physical Q rise (2 sync + 1 register).
- **Simultaneous events:**
  - q_rise while not in IDLE is ignored; a new cycle is only accepted after e_fall.
  - e_fall during FLASH_REQ/FLASH_WAIT cannot occur while MRDY=0. If it does, treat it as an abort → IDLE with o_MRDY=1.
- **Error flag:** o_timeout_err clears only on reset.

Test Plan:
- **Reset:** hold reset=0 for 3 clk mid-flash-wait → o_MRDY=1, o_DATA_OE=0, all selects 0, o_timeout_err=0 on the first edge.
- **Flash read:** read at 16'hF123; flash model drops ready 1 cycle after ce, returns 8'hA5 after 90 cycles →
  - o_MRDY low within 3 clk of Q rise;
  - o_DATA=8'hA5 with o_DATA_OE=1;
  - o_MRDY high on the cycle after ready=1;
  - selects clear after E fall.
- **Repeat flash read:** two consecutive reads at 16'hF123, ready held 1 on the second → second completes in SETTLE_CYCLES+1 cycles with the latched byte; no timeout.
- **Decode:**
  - read 16'hE010 → o_io_ce=1 only, o_MRDY stays 1;
  - read 16'h1234 → o_ram_ce=1 only;
  - write 16'hF000 → no select, o_MRDY stays 1.
- **Timeout:** flash ready held 0 forever → after 4+255 cycles, o_DATA=8'hFF, o_MRDY=1, o_timeout_err=1; it stays 1 through later good reads until reset.
- **Back-to-back:** read 16'hF001 then 16'hF002 with no idle E cycle → each completes independently with the correct bytes; no spurious second o_flash_ce pulse within one cycle.
